tsu_ts_stamp: RTL

- Sits directly downstream of tsu and consumes its o_phase/o_phase_v output.
- Converts each phase measurement into an absolute 1588 timestamp: time sampled at the valid strobe, minus the scaled phase, minus a fixed latency adjust.
- Buffers results in a small FIFO with a valid/ready output stream, plus overflow accounting, for the PTP software/CSR side.

---
 rtl/tsu_pkg.sv | 20 ++
 rtl/tsu_ts_fifo.sv | 66 ++++++
 rtl/tsu_ts_stamp.sv | 137 +++++++++++++
 3 files changed

// File: rtl/tsu_pkg.sv
// Shared types and constants for the tsu timestamp path.
// - ts_t: one 1588 time value, Q(TS_BITS-16).16 picoseconds.
// - pipe_t: stage-1 capture of one phase measurement and its config.
package tsu_pkg;

  localparam int TS_BITS      = 64;
  localparam int PHASE_BITS   = 32;
  localparam int TS_FRAC_BITS = 16;

  typedef logic [TS_BITS-1:0] ts_t;

  typedef struct packed {
    logic                  v;
    logic [PHASE_BITS-1:0] phase;
    ts_t                   tm;     // 1588 time sampled in the strobe cycle
    logic [PHASE_BITS-1:0] scale;  // ps per phase unit, Q16.16
    ts_t                   adj;    // fixed latency adjust, Q.16 ps
  } pipe_t;

endpackage

// File: rtl/tsu_ts_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   push_i, data_i  write request and data (ignored when full without pop)
//   pop_i           read request (ignored when empty)
//   data_o          head entry, forced to 0 when empty
//   full_o, empty_o occupancy flags
//   lvl_o           occupancy after the last edge
//   drop_o          push refused this cycle (full, no pop)
module tsu_ts_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   lvl_o,
  output logic          drop_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         push_ok;
  logic         pop_ok;

  // Extra pointer bit separates full from empty; pointers wrap naturally.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign lvl_o   = wr_q - rd_q;

  assign pop_ok  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push_i && (!full_o || pop_i);
  assign drop_o  = push_i && full_o && !pop_i;

  assign data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/tsu_ts_stamp.sv
// Converts tsu phase measurements into absolute 1588 timestamps:
//   ts = time_at_strobe - phase*scale - lat_adj   (mod 2^TIME_BITS)
// and queues them in a FWFT FIFO with overflow accounting.
// Ports:
//   clk, rst_n                 1588 clock, async active-low reset
//   i_time                     free-running 1588 time, Q.16 ps
//   i_phase, i_phase_v         tsu phase result and single-cycle strobe
//   i_scale                    ps per phase unit, Q16.16
//   i_lat_adj                  fixed latency adjust, Q.16 ps
//   o_ts, o_ts_v, i_ts_rdy     timestamp stream (pop on o_ts_v & i_ts_rdy)
//   o_fifo_lvl                 FIFO occupancy
//   o_ovf, o_ovf_cnt, i_ovf_clr sticky drop flag, saturating drop count, clear
module tsu_ts_stamp
  import tsu_pkg::*;
#(
  parameter int RAT_PREC_BITS = PHASE_BITS,
  parameter int TIME_BITS     = TS_BITS,
  parameter int FIFO_DEPTH    = 8,
  parameter int OVF_BITS      = 16,
  localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [TIME_BITS-1:0]     i_time,
  input  logic [RAT_PREC_BITS-1:0] i_phase,
  input  logic                     i_phase_v,
  input  logic [RAT_PREC_BITS-1:0] i_scale,
  input  logic [TIME_BITS-1:0]     i_lat_adj,
  output logic [TIME_BITS-1:0]     o_ts,
  output logic                     o_ts_v,
  input  logic                     i_ts_rdy,
  output logic [LVL_W-1:0]         o_fifo_lvl,
  output logic                     o_ovf,
  output logic [OVF_BITS-1:0]      o_ovf_cnt,
  input  logic                     i_ovf_clr
);

  function automatic logic [OVF_BITS-1:0] sat_inc(input logic [OVF_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  pipe_t                         pipe_p1_q, pipe_p1_d;
  logic                          vld_p2_q;
  logic [TIME_BITS-1:0]          tm_p2_q, prod_p2_q, adj_p2_q;
  logic [2*RAT_PREC_BITS-1:0]    prod_full;
  ts_t                           ts_p3;
  logic                          push_p3;
  logic                          empty, full, drop;
  logic                          ovf_q, ovf_d;
  logic [OVF_BITS-1:0]           cnt_q, cnt_d;

  // ---- S1: capture measurement and config in the strobe cycle ----
  always_comb begin
    pipe_p1_d   = pipe_p1_q;
    pipe_p1_d.v = i_phase_v;
    if (i_phase_v) begin
      pipe_p1_d.phase = i_phase;
      pipe_p1_d.tm    = i_time;
      pipe_p1_d.scale = i_scale;
      pipe_p1_d.adj   = i_lat_adj;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_p1_q <= '0;
    else        pipe_p1_q <= pipe_p1_d;
  end

  // ---- S2: full-width unsigned product, resized to Q.16 time ----
  assign prod_full = (2*RAT_PREC_BITS)'(pipe_p1_q.phase) *
                     (2*RAT_PREC_BITS)'(pipe_p1_q.scale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p2_q <= 1'b0;
    else        vld_p2_q <= pipe_p1_q.v;
  end

  always_ff @(posedge clk) begin
    if (pipe_p1_q.v) begin
      tm_p2_q   <= pipe_p1_q.tm;
      prod_p2_q <= TIME_BITS'(prod_full);
      adj_p2_q  <= pipe_p1_q.adj;
    end
  end

  // ---- S3: modular subtraction, written straight into the FIFO ----
  assign ts_p3   = tm_p2_q - prod_p2_q - adj_p2_q;
  assign push_p3 = vld_p2_q;

  tsu_ts_fifo #(
    .W     (TIME_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push_p3),
    .data_i  (ts_p3),
    .pop_i   (i_ts_rdy),
    .data_o  (o_ts),
    .full_o  (full),
    .empty_o (empty),
    .lvl_o   (o_fifo_lvl),
    .drop_o  (drop)
  );

  assign o_ts_v = !empty;

  // A drop coinciding with a clear wins: the count restarts at 1.
  always_comb begin
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (drop) begin
      ovf_d = 1'b1;
      cnt_d = i_ovf_clr ? OVF_BITS'(1) : sat_inc(cnt_q);
    end else if (i_ovf_clr) begin
      ovf_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_ovf     = ovf_q;
  assign o_ovf_cnt = cnt_q;

  logic unused_full;
  assign unused_full = full;

endmodule
